// File: rtl/sap1_loader_pkg.sv
// sap1_loader_pkg: state encoding and SAP-1 RAM geometry shared by the program loader.
// SAP1_LOADER_CHECKSUM_EN adds the CHECK and ERROR states.
package sap1_loader_pkg;
    localparam int SAP1_RAM_WORDS = 16;
    localparam int SAP1_ADDR_W    = 4;
    localparam int SAP1_DATA_W    = 8;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_WRITE,
        ST_RECOVER,
        ST_RELEASE
`ifdef SAP1_LOADER_CHECKSUM_EN
        , ST_CHECK,
        ST_ERROR
`endif
    } state_t;
endpackage

// File: rtl/sap1_loader_if.sv
// sap1_loader_if: valid/ready byte stream that carries the program image into the loader.
interface sap1_loader_if;
    import sap1_loader_pkg::*;
    logic                   in_valid;
    logic [SAP1_DATA_W-1:0] in_data;
    logic                   in_ready;
    modport master (output in_valid, in_data, input in_ready);
    modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/sap1_loader_pulse_timer.sv
// sap1_loader_pulse_timer: load-and-count-down timer; expired on the last cycle of the loaded duration.
module sap1_loader_pulse_timer (
    input  logic       clk,
    input  logic       clr,
    input  logic       i_load,
    input  logic [3:0] i_value,
    output logic       o_expired
);
    logic [3:0] r_cnt;
    // Load the duration on entry to a timed state, then count down and rest at zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_cnt <= '0;
        else if (i_load) r_cnt <= i_value;
        else if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
    assign o_expired = r_cnt <= 4'd1;
endmodule

// File: rtl/sap1_program_loader.sv
// sap1_program_loader: streams a 16-byte image into SAP-1 RAM via the switch-level load port.
// SAP1_LOADER_CHECKSUM_EN requires a 17th two's-complement checksum byte and reports mismatches on o_err.
module sap1_program_loader
    import sap1_loader_pkg::*;
#(
    parameter int WE_CYCLES  = 2,
    parameter int CLR_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   i_start,
    sap1_loader_if.slave           s_in,
    output logic [SAP1_ADDR_W-1:0] o_a,
    output logic [SAP1_DATA_W-1:0] o_d,
    output logic                   o_ch_s2,
    output logic                   o_ch_s4,
    output logic                   o_n_clr_cpu,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);
    localparam logic [SAP1_ADDR_W-1:0] LAST_ADDR = SAP1_ADDR_W'(SAP1_RAM_WORDS - 1);
    state_t                 r_state, w_nxt;
    logic [SAP1_ADDR_W-1:0] r_addr;
    logic [SAP1_DATA_W-1:0] r_d;
    logic r_in_ready, r_ch_s2, r_ch_s4, r_n_clr_cpu, r_busy, r_done;
    logic w_in_ready, w_ch_s2, w_ch_s4, w_n_clr_cpu, w_busy, w_done;
    logic w_xfer, w_last, w_restart, w_expired, w_tmr_load;
    logic [3:0] w_tmr_value;
`ifdef SAP1_LOADER_CHECKSUM_EN
    logic [SAP1_DATA_W-1:0] r_sum, w_sum_nxt;
    logic                   r_err, w_sum_ok;
`endif

    sap1_loader_pulse_timer u_timer (
        .clk       (clk),
        .clr       (clr),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_expired)
    );

    // Next state plus the next value of every registered output, decoded from the next state.
    always_comb begin
        w_xfer    = s_in.in_valid & r_in_ready;
        w_last    = r_addr == LAST_ADDR;
        w_restart = 1'b0;
        w_nxt     = r_state;
`ifdef SAP1_LOADER_CHECKSUM_EN
        w_sum_nxt = r_sum + s_in.in_data;
        w_sum_ok  = w_sum_nxt == '0;
`endif
        case (r_state)
            ST_IDLE:    begin w_restart = i_start; w_nxt = i_start ? ST_WAIT : ST_IDLE; end
            ST_WAIT:    w_nxt = w_xfer ? ST_SETUP : ST_WAIT;
            ST_SETUP:   w_nxt = ST_WRITE;
            ST_WRITE:   w_nxt = w_expired ? ST_RECOVER : ST_WRITE;
`ifdef SAP1_LOADER_CHECKSUM_EN
            ST_RECOVER: w_nxt = w_last ? ST_CHECK : ST_WAIT;
            ST_CHECK:   w_nxt = w_xfer ? (w_sum_ok ? ST_RELEASE : ST_ERROR) : ST_CHECK;
            ST_ERROR:   begin w_restart = i_start; w_nxt = i_start ? ST_WAIT : ST_ERROR; end
`else
            ST_RECOVER: w_nxt = w_last ? ST_RELEASE : ST_WAIT;
`endif
            ST_RELEASE: w_nxt = w_expired ? ST_IDLE : ST_RELEASE;
            default:    w_nxt = ST_IDLE;
        endcase
        w_tmr_load  = (w_nxt != r_state) && (w_nxt == ST_WRITE || w_nxt == ST_RELEASE);
        w_tmr_value = (w_nxt == ST_WRITE) ? 4'(WE_CYCLES) : 4'(CLR_CYCLES);
`ifdef SAP1_LOADER_CHECKSUM_EN
        w_in_ready  = w_nxt == ST_WAIT || w_nxt == ST_CHECK;
        w_busy      = !(w_nxt == ST_IDLE || w_nxt == ST_ERROR);
`else
        w_in_ready  = w_nxt == ST_WAIT;
        w_busy      = w_nxt != ST_IDLE;
`endif
        w_ch_s2     = w_nxt == ST_IDLE || w_nxt == ST_RELEASE;
        w_ch_s4     = w_nxt != ST_WRITE;
        w_n_clr_cpu = w_nxt == ST_IDLE;
        w_done      = r_state == ST_RELEASE && w_nxt == ST_IDLE;
    end

    // State register and registered control outputs; clr forces the idle/execute levels at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_ch_s2     <= 1'b1;
            r_ch_s4     <= 1'b1;
            r_n_clr_cpu <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_in_ready  <= w_in_ready;
            r_ch_s2     <= w_ch_s2;
            r_ch_s4     <= w_ch_s4;
            r_n_clr_cpu <= w_n_clr_cpu;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    // Address advances only after RECOVER so a/d never move while the write strobe is low.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_addr <= '0;
            r_d    <= '0;
        end else begin
            r_addr <= w_restart ? '0 : (r_state == ST_RECOVER && !w_last) ? r_addr + 1'b1 : r_addr;
            r_d    <= (r_state == ST_WAIT && w_xfer) ? s_in.in_data : r_d;
        end
    end

`ifdef SAP1_LOADER_CHECKSUM_EN
    // Running byte sum and sticky error; both cleared by a fresh start.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else begin
            r_sum <= w_restart ? '0 : (r_state == ST_WAIT && w_xfer) ? w_sum_nxt : r_sum;
            r_err <= w_restart ? 1'b0 : (r_state == ST_CHECK && w_xfer && !w_sum_ok) ? 1'b1 : r_err;
        end
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign s_in.in_ready = r_in_ready;
    assign o_a           = r_addr;
    assign o_d           = r_d;
    assign o_ch_s2       = r_ch_s2;
    assign o_ch_s4       = r_ch_s4;
    assign o_n_clr_cpu   = r_n_clr_cpu;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
endmodule
